cla_word_sequencer: RTL and testbench
=====================================

// Module: cla_word_sequencer
// PURPOSE
// Multi-cycle adder controller for WIDTH-bit operands built on one shared 4-bit
// carrylookahead_adder slice, which it instantiates internally. Accepts operands
// over a valid/ready handshake and feeds one nibble per cycle through the slice,
// LSB nibble first. The carry is registered between nibbles. Presents the sum
// and carry-out over a valid/ready handshake. Serves wide adds where area matters
// more than latency.
// PARAMETERS
// WIDTH   16   operand/sum width in bits; must be a multiple of 4 and >= 4
//              (NSLICE = WIDTH/4 is a derived localparam)
// PORTS
// clk        in   1      rising-edge clock
// rst_n      in   1      asynchronous active-low reset
// in_valid   in   1      operand set a/b/cin is valid
// in_ready   out  1      block can accept operands
// a          in   WIDTH  addend A
// b          in   WIDTH  addend B
// cin        in   1      carry-in to nibble 0
// out_valid  out  1      sum/cout are valid
// out_ready  in   1      consumer accepts result
// sum        out  WIDTH  registered result A+B+cin, low WIDTH bits
// cout       out  1      registered carry out of the top nibble
// busy       out  1      high while in the BUSY state
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, busy=0,
//   sum=0, cout=0. Internal operand, carry and index registers clear to 0.
// - FSM states: IDLE, BUSY, DONE. All outputs are registered or decoded from state.
//   IDLE: in_ready=1. On in_valid&in_ready, latch a, b and cin into the carry
//     register, set idx=0, and go to BUSY. Otherwise stay in IDLE.
//   BUSY: in_ready=0, busy=1. Each cycle the slice gets a_r[4*idx+:4],
//     b_r[4*idx+:4] and carry_r. At the clock edge, write the slice sum to
//     sum[4*idx+:4], write the slice cout to carry_r, and increment idx.
//     When idx==NSLICE-1, also set cout=slice cout and go to DONE.
//   DONE: out_valid=1, in_ready=0. Stay in DONE while out_ready=0.
//     On out_ready=1, go to IDLE and clear out_valid.
// - Latency: out_valid rises exactly NSLICE clock edges after the accept edge.
//   For WIDTH=16 that is 4 edges.
// - Throughput: one operation per NSLICE+2 cycles. No overlap between operations.
// - Stability while out_valid=1: sum and cout hold their values until the
//   handshake completes. The a and b inputs are don't-care after acceptance.
// - in_valid while not IDLE: ignored, because in_ready=0. The producer must hold
//   its data until it sees in_ready.
// - Simultaneous events:
//   - out_ready=1 in DONE with in_valid=1: go to IDLE only. New operands are
//     accepted on the following cycle.
//   - out_ready with state!=DONE: ignored.
// - Width and arithmetic:
//   - The result is modulo 2^WIDTH; the final carry appears only on cout.
//   - The carry ripples between nibbles only through carry_r, so there is no
//     combinational path from a, b or cin to any output.
// - Reset mid-operation: rst_n low in BUSY or DONE aborts the add immediately.
//   All outputs return to their reset values, and the result is lost.
// - Between operations, sum keeps the last result until the next operation
//   starts overwriting nibbles.
// TESTING
// Run all tests with WIDTH=16 and out_ready=1 unless stated otherwise.
// T1: a=16'h1234, b=16'h4321, cin=0 -> after 4 edges: out_valid=1,
//     sum=16'h5555, cout=0.
// T2: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1. This checks the
//     carry ripple through all 4 nibbles.
// T3: a=16'h8F0F, b=16'h80F1, cin=0 -> sum=16'h1000, cout=1. Also check
//     busy=1 for exactly 4 cycles.
// T4: backpressure. With out_ready=0 for 3 cycles after out_valid, sum and
//     cout must stay stable and in_ready=0. A second in_valid pulse during this
//     time is not accepted. After out_ready=1: IDLE, then the second operand is
//     accepted.
// T5: reset mid-op. Assert rst_n=0 after 2 BUSY cycles of T1 -> out_valid=0,
//     sum=0, in_ready=1. A new T2 run afterwards must give the T2 result.
// T6: randomized self-check against a+b+cin, 200 vectors, with in_valid
//     asserted back-to-back.

Source files
------------

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: adds two WIDTH-bit words one nibble per cycle through a
// single shared 4-bit carry-lookahead slice. Operands arrive on a valid/ready
// handshake and the result leaves on another. The carry passes between nibbles
// only through a register, so no input reaches an output combinationally.

module carrylookahead_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry comes straight from generate/propagate terms and cin, with no ripple
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

module cla_word_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [IDX_W-1:0] idx_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic [3:0]       sl_sum;
  logic             sl_cout;

  // The current nibble of each latched operand is shifted down into the slice
  assign sl_a = 4'(a_q >> (4 * idx_q));
  assign sl_b = 4'(b_q >> (4 * idx_q));

  carrylookahead_adder u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  // Control FSM with registered handshake flags; also owns the operand, carry and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) sum_q[4*i +: 4] <= sl_sum;
          end
          carry_q <= sl_cout;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NSLICE - 1)) begin
            cout_q      <= sl_cout;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE here means a waiting producer is taken on the next cycle
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Directed and randomized bench for cla_word_sequencer at WIDTH=16. Expected
// sums come from plain 17-bit addition of the operands and carry-in.

module tb_cla_word_sequencer;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic             cin = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_word_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Reference: the full-width sum with its carry in bit WIDTH
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accept edge; waits for out_valid and checks result and timing
  task automatic wait_result(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                             input logic xc, input string tag);
    logic [WIDTH:0] e;
    int n;
    int bcnt;
    e = ref_add(xa, xb, xc);
    n = 0;
    bcnt = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      if (busy === 1'b1) bcnt++;
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(e[WIDTH-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(e[WIDTH]));
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  // Present one operand set from IDLE, accept it, then scramble the inputs
  task automatic issue(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic xc, input string tag);
    a = xa;
    b = xb;
    cin = xc;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    cin = 1'($urandom);
    check({tag, "_accept_busy"}, 32'(busy), 32'd1);
    wait_result(xa, xb, xc, tag);
  endtask

  task automatic complete(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] hold_sum;
    logic             hold_cout;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1..T3 basic adds
    out_ready = 1'b1;
    issue(16'h1234, 16'h4321, 1'b0, "T1");
    check("T1_sum_const", 32'(sum), 32'h5555);
    complete("T1");
    issue(16'hFFFF, 16'h0000, 1'b1, "T2");
    check("T2_sum_const", 32'(sum), 32'h0000);
    check("T2_cout_const", 32'(cout), 32'd1);
    complete("T2");
    issue(16'h8F0F, 16'h80F1, 1'b0, "T3");
    check("T3_sum_const", 32'(sum), 32'h1000);
    check("T3_cout_const", 32'(cout), 32'd1);
    complete("T3");

    // T4 backpressure with a second request waiting
    out_ready = 1'b0;
    issue(16'hABCD, 16'h1357, 1'b1, "T4a");
    hold_sum = sum;
    hold_cout = cout;
    a = 16'h0F0F;
    b = 16'h0101;
    cin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("T4_hold_out_valid", 32'(out_valid), 32'd1);
      check("T4_hold_sum", 32'(sum), 32'(hold_sum));
      check("T4_hold_cout", 32'(cout), 32'(hold_cout));
      check("T4_hold_in_ready", 32'(in_ready), 32'd0);
      check("T4_hold_busy", 32'(busy), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("T4_release_out_valid", 32'(out_valid), 32'd0);
    check("T4_release_in_ready", 32'(in_ready), 32'd1);
    check("T4_release_not_accepted", 32'(busy), 32'd0);
    tick();
    in_valid = 1'b0;
    check("T4b_accept_busy", 32'(busy), 32'd1);
    wait_result(16'h0F0F, 16'h0101, 1'b0, "T4b");
    complete("T4b");

    // T5 reset in the middle of a BUSY run, then a clean T2
    a = 16'h1234;
    b = 16'h4321;
    cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("T5_mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("T5_rst_out_valid", 32'(out_valid), 32'd0);
    check("T5_rst_sum", 32'(sum), 32'd0);
    check("T5_rst_in_ready", 32'(in_ready), 32'd1);
    check("T5_rst_busy", 32'(busy), 32'd0);
    check("T5_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'hFFFF, 16'h0000, 1'b1, "T5_T2");
    complete("T5_T2");

    // T6 randomized with in_valid held high across operations
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      if (i == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
      if (i == 1) begin ra = 16'h0000; rb = 16'h0000; rc = 1'b0; end
      a = ra;
      b = rb;
      cin = rc;
      tick();
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      cin = 1'($urandom);
      wait_result(ra, rb, rc, "T6");
      tick();
      check("T6_idle_in_ready", 32'(in_ready), 32'd1);
      check("T6_idle_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
